// File: rtl/inst_dispatch.sv
// Registers the 34-bit core instruction bus and fans it out as per-unit strobes.
// Also tracks the operation phase and its beat count, and raises sticky protocol-violation flags.
module inst_dispatch #(
    parameter int inst_bw = 34,
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [inst_bw-1:0] inst,
    input  logic               ofifo_valid,
    output logic               xmem_cen,
    output logic               xmem_wen,
    output logic [addr_bw-1:0] xmem_addr,
    output logic               pmem_cen,
    output logic               pmem_wen,
    output logic [addr_bw-1:0] pmem_addr,
    output logic               ofifo_rd,
    output logic               ififo_wr,
    output logic               ififo_rd,
    output logic               l0_rd,
    output logic               l0_wr,
    output logic               execute,
    output logic               load,
    output logic               acc,
    output logic [2:0]         phase,
    output logic [cnt_bw-1:0]  beat_cnt,
    output logic [4:0]         err
);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_XWR   = 3'd1,
        PH_FILL  = 3'd2,
        PH_LOAD  = 3'd3,
        PH_EXEC  = 3'd4,
        PH_DRAIN = 3'd5,
        PH_ACC   = 3'd6
    } phase_t;

    localparam int XA_LO = 7;
    localparam int PA_LO = XA_LO + addr_bw + 2;
    localparam int ACC_B = PA_LO + addr_bw + 2;

    function automatic logic [cnt_bw-1:0] sat_inc(input logic [cnt_bw-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Wrap from the top address back to 0 counts as sequential.
    function automatic logic addr_is_next(input logic [addr_bw-1:0] prev,
                                          input logic [addr_bw-1:0] nxt);
        logic [addr_bw-1:0] succ;
        succ = prev + 1'b1;
        return nxt == succ;
    endfunction

    // Stage p0: field extraction and decode of the incoming instruction
    logic               acc_p0, pmem_cen_p0, pmem_wen_p0, xmem_cen_p0, xmem_wen_p0;
    logic               ofifo_rd_p0, ififo_wr_p0, ififo_rd_p0, l0_rd_p0, l0_wr_p0;
    logic               execute_p0, load_p0;
    logic [addr_bw-1:0] pmem_addr_p0, xmem_addr_p0;

    assign acc_p0       = inst[ACC_B];
    assign pmem_cen_p0  = inst[PA_LO+addr_bw+1];
    assign pmem_wen_p0  = inst[PA_LO+addr_bw];
    assign pmem_addr_p0 = inst[PA_LO +: addr_bw];
    assign xmem_cen_p0  = inst[XA_LO+addr_bw+1];
    assign xmem_wen_p0  = inst[XA_LO+addr_bw];
    assign xmem_addr_p0 = inst[XA_LO +: addr_bw];
    assign ofifo_rd_p0  = inst[6];
    assign ififo_wr_p0  = inst[5];
    assign ififo_rd_p0  = inst[4];
    assign l0_rd_p0     = inst[3];
    assign l0_wr_p0     = inst[2];
    assign execute_p0   = inst[1];
    assign load_p0      = inst[0];

    phase_t             phase_p0, phase_p1;
    logic [cnt_bw-1:0]  beat_p0, beat_p1;
    logic [4:0]         err_set_p0, err_p1;
    logic               ofifo_rd_p1;
    logic [addr_bw-1:0] xmem_addr_p1, pmem_addr_p1;

    always_comb begin
        phase_p0 = PH_IDLE;
        if (acc_p0)                          phase_p0 = PH_ACC;
        else if (ofifo_rd_p0)                phase_p0 = PH_DRAIN;
        else if (execute_p0)                 phase_p0 = PH_EXEC;
        else if (load_p0)                    phase_p0 = PH_LOAD;
        else if (l0_wr_p0 || ififo_wr_p0)    phase_p0 = PH_FILL;
        else if (!xmem_cen_p0 && !xmem_wen_p0) phase_p0 = PH_XWR;
    end

    always_comb begin
        beat_p0 = '0;
        if (phase_p0 == PH_IDLE)       beat_p0 = '0;
        else if (phase_p0 == phase_p1) beat_p0 = sat_inc(beat_p1);
        else                           beat_p0 = {{(cnt_bw-1){1'b0}}, 1'b1};
    end

    // err[1] looks at the strobe already on the output, so it lands one edge after the read.
    always_comb begin
        err_set_p0    = '0;
        err_set_p0[0] = load_p0 & execute_p0;
        err_set_p0[1] = ofifo_rd_p1 & ~ofifo_valid;
        err_set_p0[2] = ~pmem_cen_p0 & ~pmem_wen_p0 & ~ofifo_rd_p0;
        err_set_p0[3] = ~xmem_cen_p0 & ~xmem_wen_p0 & (l0_wr_p0 | ififo_wr_p0);
        if ((phase_p0 == phase_p1) && (beat_p1 != '0)) begin
            if (phase_p0 == PH_XWR)
                err_set_p0[4] = ~addr_is_next(xmem_addr_p1, xmem_addr_p0);
            else if (phase_p0 == PH_DRAIN)
                err_set_p0[4] = ~addr_is_next(pmem_addr_p1, pmem_addr_p0);
        end
    end

    // Stage p1: registered outputs
    logic xmem_cen_p1, xmem_wen_p1, pmem_cen_p1, pmem_wen_p1;
    logic ififo_wr_p1, ififo_rd_p1, l0_rd_p1, l0_wr_p1, execute_p1, load_p1, acc_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            xmem_cen_p1  <= 1'b1;
            xmem_wen_p1  <= 1'b1;
            pmem_cen_p1  <= 1'b1;
            pmem_wen_p1  <= 1'b1;
            xmem_addr_p1 <= '0;
            pmem_addr_p1 <= '0;
            ofifo_rd_p1  <= 1'b0;
            ififo_wr_p1  <= 1'b0;
            ififo_rd_p1  <= 1'b0;
            l0_rd_p1     <= 1'b0;
            l0_wr_p1     <= 1'b0;
            execute_p1   <= 1'b0;
            load_p1      <= 1'b0;
            acc_p1       <= 1'b0;
            phase_p1     <= PH_IDLE;
            beat_p1      <= '0;
            err_p1       <= '0;
        end else begin
            xmem_cen_p1  <= xmem_cen_p0;
            xmem_wen_p1  <= xmem_wen_p0;
            pmem_cen_p1  <= pmem_cen_p0;
            pmem_wen_p1  <= pmem_wen_p0;
            xmem_addr_p1 <= xmem_addr_p0;
            pmem_addr_p1 <= pmem_addr_p0;
            ofifo_rd_p1  <= ofifo_rd_p0;
            ififo_wr_p1  <= ififo_wr_p0;
            ififo_rd_p1  <= ififo_rd_p0;
            l0_rd_p1     <= l0_rd_p0;
            l0_wr_p1     <= l0_wr_p0;
            execute_p1   <= execute_p0;
            load_p1      <= load_p0;
            acc_p1       <= acc_p0;
            phase_p1     <= phase_p0;
            beat_p1      <= beat_p0;
            err_p1       <= err_p1 | err_set_p0;
        end
    end

    assign xmem_cen  = xmem_cen_p1;
    assign xmem_wen  = xmem_wen_p1;
    assign xmem_addr = xmem_addr_p1;
    assign pmem_cen  = pmem_cen_p1;
    assign pmem_wen  = pmem_wen_p1;
    assign pmem_addr = pmem_addr_p1;
    assign ofifo_rd  = ofifo_rd_p1;
    assign ififo_wr  = ififo_wr_p1;
    assign ififo_rd  = ififo_rd_p1;
    assign l0_rd     = l0_rd_p1;
    assign l0_wr     = l0_wr_p1;
    assign execute   = execute_p1;
    assign load      = load_p1;
    assign acc       = acc_p1;
    assign phase     = phase_p1;
    assign beat_cnt  = beat_p1;
    assign err       = err_p1;

endmodule
